test_result_checker: RTL and testbench

TEST_RESULT_CHECKER -- requirements
Module: test_result_checker

---
 rtl/test_result_checker.sv | 154 +++++++++++++++
 tb/tb_test_result_checker.sv | 224 ++++++++++++++++++++++
 2 files changed

// File: rtl/test_result_checker.sv
// Round-robin compare checker with pass/fail/timeout evaluation.
// Optional first-mismatch capture enabled by TEST_RESULT_CHECKER_FIRST_FAIL_EN.
module test_result_checker #(
    parameter int DATA_WIDTH      = 32,
    parameter int NUM_CHANNELS    = 2,
    parameter int NUMBER_OF_TESTS = 16,
    parameter int TIMEOUT_CYCLES  = 50000000
) (
    input  logic                               clk,
    input  logic                               rst,
    input  logic                               start,
    input  logic                               done,
    input  logic [NUM_CHANNELS-1:0]            cmp_valid,
    output logic [NUM_CHANNELS-1:0]            cmp_ready,
    input  logic [NUM_CHANNELS*DATA_WIDTH-1:0] cmp_expected,
    input  logic [NUM_CHANNELS*DATA_WIDTH-1:0] cmp_measured,
    output logic [15:0]                        test_count,
    output logic [15:0]                        fail_count,
    output logic [2:0]                         state,
    output logic                               test_passed,
    output logic                               test_failed,
    output logic                               timeout_flag,
    output logic [2:0]                         last_fail_channel
`ifdef TEST_RESULT_CHECKER_FIRST_FAIL_EN
    ,
    output logic [DATA_WIDTH-1:0]              first_fail_expected,
    output logic [DATA_WIDTH-1:0]              first_fail_measured,
    output logic                               first_fail_valid
`endif
);

    localparam logic [2:0] S_IDLE    = 3'd0;
    localparam logic [2:0] S_RUNNING = 3'd1;
    localparam logic [2:0] S_PASSED  = 3'd2;
    localparam logic [2:0] S_FAILED  = 3'd3;
    localparam logic [2:0] S_TIMEOUT = 3'd4;

    logic [2:0]            ptr;
    logic                  grant_found;
    logic [2:0]            grant_idx;
    logic [DATA_WIDTH-1:0] sel_expected;
    logic [DATA_WIDTH-1:0] sel_measured;
    logic                  running;
    logic                  accept;
    logic                  mismatch;
    logic [15:0]           test_next;
    logic [15:0]           fail_next;
    logic [31:0]           watchdog;

    function automatic logic [15:0] sat_inc(input logic [15:0] v);
        return (v == 16'hFFFF) ? v : v + 16'd1;
    endfunction

    // First pass looks at channels at or above the pointer, second pass wraps.
    always_comb begin
        grant_found = 1'b0;
        grant_idx   = 3'd0;
        for (int j = 0; j < NUM_CHANNELS; j++) begin
            if (!grant_found && cmp_valid[j] && (3'(j) >= ptr)) begin
                grant_found = 1'b1;
                grant_idx   = 3'(j);
            end
        end
        for (int j = 0; j < NUM_CHANNELS; j++) begin
            if (!grant_found && cmp_valid[j]) begin
                grant_found = 1'b1;
                grant_idx   = 3'(j);
            end
        end
    end

    assign running = (state == S_RUNNING);
    assign accept  = running && grant_found && !rst;

    always_comb begin
        cmp_ready    = '0;
        sel_expected = '0;
        sel_measured = '0;
        for (int j = 0; j < NUM_CHANNELS; j++) begin
            cmp_ready[j] = accept && (grant_idx == 3'(j));
            if (grant_idx == 3'(j)) begin
                sel_expected = cmp_expected[j*DATA_WIDTH +: DATA_WIDTH];
                sel_measured = cmp_measured[j*DATA_WIDTH +: DATA_WIDTH];
            end
        end
    end

    assign mismatch  = (sel_expected != sel_measured);
    assign test_next = accept ? sat_inc(test_count) : test_count;
    assign fail_next = (accept && mismatch) ? sat_inc(fail_count) : fail_count;

    assign test_passed  = (state == S_PASSED);
    assign test_failed  = (state == S_FAILED) || (state == S_TIMEOUT);
    assign timeout_flag = (state == S_TIMEOUT);

    always_ff @(posedge clk) begin
        if (rst) begin
            ptr <= 3'd0;
        end else if (accept) begin
            ptr <= (grant_idx == 3'(NUM_CHANNELS - 1)) ? 3'd0 : grant_idx + 3'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state             <= S_IDLE;
            test_count        <= 16'd0;
            fail_count        <= 16'd0;
            watchdog          <= 32'd0;
            last_fail_channel <= 3'd0;
        end else if (start) begin
            state             <= S_RUNNING;
            test_count        <= 16'd0;
            fail_count        <= 16'd0;
            watchdog          <= 32'd0;
            last_fail_channel <= 3'd0;
        end else if (running) begin
            test_count <= test_next;
            fail_count <= fail_next;
            if (accept && mismatch) begin
                last_fail_channel <= grant_idx;
            end
            // done wins over a watchdog expiry landing on the same cycle
            if (done) begin
                if (fail_next != 16'd0) begin
                    state <= S_FAILED;
                end else if (test_next == 16'(NUMBER_OF_TESTS)) begin
                    state <= S_PASSED;
                end else begin
                    state <= S_FAILED;
                end
            end else if (watchdog == 32'(TIMEOUT_CYCLES - 1)) begin
                state <= S_TIMEOUT;
            end else begin
                watchdog <= watchdog + 32'd1;
            end
        end
    end

`ifdef TEST_RESULT_CHECKER_FIRST_FAIL_EN
    always_ff @(posedge clk) begin
        if (rst || start) begin
            first_fail_valid    <= 1'b0;
            first_fail_expected <= '0;
            first_fail_measured <= '0;
        end else if (accept && mismatch && !first_fail_valid) begin
            first_fail_valid    <= 1'b1;
            first_fail_expected <= sel_expected;
            first_fail_measured <= sel_measured;
        end
    end
`endif

endmodule

// File: tb/tb_test_result_checker.sv
// Directed bench for test_result_checker: pass, fail, round-robin, count mismatch,
// same-cycle done, watchdog timeout and mid-run reset.
module tb_test_result_checker;

    localparam int DW = 32;
    localparam int NC = 2;

    logic             clk = 1'b0;
    logic             rst, start, done;
    logic [NC-1:0]    cmp_valid;
    logic [NC-1:0]    cmp_ready;
    logic [NC*DW-1:0] cmp_expected, cmp_measured;
    logic [15:0]      test_count, fail_count;
    logic [2:0]       state;
    logic             test_passed, test_failed, timeout_flag;
    logic [2:0]       last_fail_channel;
`ifdef TEST_RESULT_CHECKER_FIRST_FAIL_EN
    logic [DW-1:0]    first_fail_expected, first_fail_measured;
    logic             first_fail_valid;
`endif

    int total = 0;
    int bad   = 0;

    test_result_checker #(
        .DATA_WIDTH(DW), .NUM_CHANNELS(NC), .NUMBER_OF_TESTS(16), .TIMEOUT_CYCLES(100)
    ) dut (
        .clk(clk), .rst(rst), .start(start), .done(done),
        .cmp_valid(cmp_valid), .cmp_ready(cmp_ready),
        .cmp_expected(cmp_expected), .cmp_measured(cmp_measured),
        .test_count(test_count), .fail_count(fail_count), .state(state),
        .test_passed(test_passed), .test_failed(test_failed), .timeout_flag(timeout_flag),
        .last_fail_channel(last_fail_channel)
`ifdef TEST_RESULT_CHECKER_FIRST_FAIL_EN
        ,
        .first_fail_expected(first_fail_expected),
        .first_fail_measured(first_fail_measured),
        .first_fail_valid(first_fail_valid)
`endif
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_start();
        start = 1'b1;
        tick();
        start = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1; start = 1'b0; done = 1'b0;
        cmp_valid = '0; cmp_expected = '0; cmp_measured = '0;
        tick(); tick();
        rst = 1'b0;
        total++; if (state !== 3'd0) begin bad++; $display("FAIL reset_state got=%0d want=0", state); end
        total++; if (test_count !== 16'd0) begin bad++; $display("FAIL reset_test_count got=%0d want=0", test_count); end
        total++; if (fail_count !== 16'd0) begin bad++; $display("FAIL reset_fail_count got=%0d want=0", fail_count); end
        total++; if (cmp_ready !== 2'b00) begin bad++; $display("FAIL reset_ready got=%b want=00", cmp_ready); end
        total++; if ({test_passed, test_failed, timeout_flag} !== 3'b000) begin bad++; $display("FAIL reset_flags got=%b want=000", {test_passed, test_failed, timeout_flag}); end
        total++; if (last_fail_channel !== 3'd0) begin bad++; $display("FAIL reset_last_fail got=%0d want=0", last_fail_channel); end
    endtask

    task automatic test_pass();
        do_start();
        total++; if (state !== 3'd1) begin bad++; $display("FAIL pass_running got=%0d want=1", state); end
        cmp_expected = {32'h0, 32'hA5A5A5A5};
        cmp_measured = {32'h0, 32'hA5A5A5A5};
        for (int i = 0; i < 16; i++) begin
            cmp_valid = 2'b01;
            #1;
            total++; if (cmp_ready !== 2'b01) begin bad++; $display("FAIL pass_ready[%0d] got=%b want=01", i, cmp_ready); end
            tick();
        end
        cmp_valid = 2'b00;
        total++; if (test_count !== 16'd16) begin bad++; $display("FAIL pass_count_pre got=%0d want=16", test_count); end
        done = 1'b1; tick(); done = 1'b0;
        total++; if (state !== 3'd2) begin bad++; $display("FAIL pass_state got=%0d want=2", state); end
        total++; if (test_passed !== 1'b1) begin bad++; $display("FAIL pass_flag got=%b want=1", test_passed); end
        total++; if (test_failed !== 1'b0) begin bad++; $display("FAIL pass_failed_flag got=%b want=0", test_failed); end
        total++; if (test_count !== 16'd16) begin bad++; $display("FAIL pass_test_count got=%0d want=16", test_count); end
        total++; if (fail_count !== 16'd0) begin bad++; $display("FAIL pass_fail_count got=%0d want=0", fail_count); end
        // done outside RUNNING is ignored
        done = 1'b1; tick(); done = 1'b0;
        total++; if (state !== 3'd2) begin bad++; $display("FAIL pass_done_ignored got=%0d want=2", state); end
        // start and done together: start wins
        start = 1'b1; done = 1'b1; tick(); start = 1'b0; done = 1'b0;
        total++; if (state !== 3'd1) begin bad++; $display("FAIL start_beats_done got=%0d want=1", state); end
        total++; if (test_count !== 16'd0) begin bad++; $display("FAIL start_clears_count got=%0d want=0", test_count); end
    endtask

    task automatic test_fail();
        logic [31:0] e, m;
        do_start();
        for (int i = 0; i < 16; i++) begin
            e = (i == 4) ? 32'h1 : 32'h12345678;
            m = (i == 4) ? 32'h2 : 32'h12345678;
            cmp_expected = {e, 32'h0};
            cmp_measured = {m, 32'h0};
            cmp_valid = 2'b10;
            #1;
            total++; if (cmp_ready !== 2'b10) begin bad++; $display("FAIL fail_ready[%0d] got=%b want=10", i, cmp_ready); end
            tick();
        end
        cmp_valid = 2'b00;
        done = 1'b1; tick(); done = 1'b0;
        total++; if (state !== 3'd3) begin bad++; $display("FAIL fail_state got=%0d want=3", state); end
        total++; if (fail_count !== 16'd1) begin bad++; $display("FAIL fail_fail_count got=%0d want=1", fail_count); end
        total++; if (test_count !== 16'd16) begin bad++; $display("FAIL fail_test_count got=%0d want=16", test_count); end
        total++; if (last_fail_channel !== 3'd1) begin bad++; $display("FAIL fail_last_channel got=%0d want=1", last_fail_channel); end
        total++; if ({test_passed, test_failed} !== 2'b01) begin bad++; $display("FAIL fail_flags got=%b want=01", {test_passed, test_failed}); end
`ifdef TEST_RESULT_CHECKER_FIRST_FAIL_EN
        total++; if (first_fail_expected !== 32'h1) begin bad++; $display("FAIL first_fail_expected got=%h want=1", first_fail_expected); end
        total++; if (first_fail_measured !== 32'h2) begin bad++; $display("FAIL first_fail_measured got=%h want=2", first_fail_measured); end
        total++; if (first_fail_valid !== 1'b1) begin bad++; $display("FAIL first_fail_valid got=%b want=1", first_fail_valid); end
`endif
    endtask

    task automatic test_round_robin();
        rst = 1'b1; tick(); rst = 1'b0;
        do_start();
        cmp_expected = {32'hCAFE0001, 32'hCAFE0000};
        cmp_measured = {32'hCAFE0001, 32'hCAFE0000};
        cmp_valid = 2'b11;
        for (int i = 0; i < 8; i++) begin
            #1;
            total++; if (cmp_ready !== ((i % 2 == 0) ? 2'b01 : 2'b10)) begin bad++; $display("FAIL rr_grant[%0d] got=%b want=%b", i, cmp_ready, (i % 2 == 0) ? 2'b01 : 2'b10); end
            tick();
        end
        cmp_valid = 2'b00;
        total++; if (test_count !== 16'd8) begin bad++; $display("FAIL rr_test_count got=%0d want=8", test_count); end
        total++; if (fail_count !== 16'd0) begin bad++; $display("FAIL rr_fail_count got=%0d want=0", fail_count); end
        done = 1'b1; tick(); done = 1'b0;
        total++; if (state !== 3'd3) begin bad++; $display("FAIL rr_state got=%0d want=3", state); end
    endtask

    task automatic test_count_mismatch();
        do_start();
        cmp_expected = {32'h0, 32'h00000077};
        cmp_measured = {32'h0, 32'h00000077};
        cmp_valid = 2'b01;
        for (int i = 0; i < 10; i++) tick();
        cmp_valid = 2'b00;
        done = 1'b1; tick(); done = 1'b0;
        total++; if (test_count !== 16'd10) begin bad++; $display("FAIL cnt_test_count got=%0d want=10", test_count); end
        total++; if (state !== 3'd3) begin bad++; $display("FAIL cnt_state got=%0d want=3", state); end
        total++; if ({test_passed, test_failed} !== 2'b01) begin bad++; $display("FAIL cnt_flags got=%b want=01", {test_passed, test_failed}); end
    endtask

    task automatic test_done_same_cycle();
        do_start();
        cmp_expected = {32'h0, 32'h5A5A0000};
        cmp_measured = {32'h0, 32'h5A5A0000};
        cmp_valid = 2'b01;
        for (int i = 0; i < 15; i++) tick();
        done = 1'b1; tick(); done = 1'b0;
        cmp_valid = 2'b00;
        total++; if (state !== 3'd2) begin bad++; $display("FAIL same_cycle_state got=%0d want=2", state); end
        total++; if (test_count !== 16'd16) begin bad++; $display("FAIL same_cycle_count got=%0d want=16", test_count); end
    endtask

    task automatic test_timeout();
        do_start();
        cmp_expected = {32'h0, 32'h5};
        cmp_measured = {32'h0, 32'h6};
        cmp_valid = 2'b01;
        for (int i = 0; i < 3; i++) tick();
        cmp_valid = 2'b00;
        for (int i = 0; i < 96; i++) tick();
        total++; if (state !== 3'd1) begin bad++; $display("FAIL to_still_running got=%0d want=1", state); end
        tick();
        total++; if (state !== 3'd4) begin bad++; $display("FAIL to_state got=%0d want=4", state); end
        total++; if ({test_passed, test_failed, timeout_flag} !== 3'b011) begin bad++; $display("FAIL to_flags got=%b want=011", {test_passed, test_failed, timeout_flag}); end
        total++; if (fail_count !== 16'd3) begin bad++; $display("FAIL to_fail_count got=%0d want=3", fail_count); end
        tick();
        total++; if (state !== 3'd4) begin bad++; $display("FAIL to_hold got=%0d want=4", state); end
        do_start();
        total++; if (state !== 3'd1) begin bad++; $display("FAIL to_restart_state got=%0d want=1", state); end
        total++; if ({test_count, fail_count} !== 32'd0) begin bad++; $display("FAIL to_restart_counts got=%0d/%0d want=0/0", test_count, fail_count); end
        total++; if ({test_passed, test_failed, timeout_flag} !== 3'b000) begin bad++; $display("FAIL to_restart_flags got=%b want=000", {test_passed, test_failed, timeout_flag}); end
        // done on the expiry cycle takes priority over the watchdog
        for (int i = 0; i < 99; i++) tick();
        done = 1'b1; tick(); done = 1'b0;
        total++; if (state !== 3'd3) begin bad++; $display("FAIL to_done_priority got=%0d want=3", state); end
        total++; if (timeout_flag !== 1'b0) begin bad++; $display("FAIL to_done_flag got=%b want=0", timeout_flag); end
    endtask

    task automatic test_reset_mid_run();
        do_start();
        cmp_expected = {32'h0, 32'h1};
        cmp_measured = {32'h0, 32'h3};
        cmp_valid = 2'b01;
        tick(); tick();
        total++; if (test_count !== 16'd2) begin bad++; $display("FAIL mid_pre_count got=%0d want=2", test_count); end
        rst = 1'b1; start = 1'b1; done = 1'b1;
        #1;
        total++; if (cmp_ready !== 2'b00) begin bad++; $display("FAIL mid_ready_in_rst got=%b want=00", cmp_ready); end
        tick();
        rst = 1'b0; start = 1'b0; done = 1'b0;
        total++; if (state !== 3'd0) begin bad++; $display("FAIL mid_state got=%0d want=0", state); end
        total++; if ({test_count, fail_count} !== 32'd0) begin bad++; $display("FAIL mid_counts got=%0d/%0d want=0/0", test_count, fail_count); end
        total++; if (cmp_ready !== 2'b00) begin bad++; $display("FAIL mid_ready got=%b want=00", cmp_ready); end
        total++; if (last_fail_channel !== 3'd0) begin bad++; $display("FAIL mid_last_fail got=%0d want=0", last_fail_channel); end
        cmp_valid = 2'b00;
    endtask

    initial begin
        test_reset();
        test_pass();
        test_fail();
        test_round_robin();
        test_count_mismatch();
        test_done_same_cycle();
        test_timeout();
        test_reset_mid_run();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
